// File: rtl/cpu_run_pkg.sv
// Shared types for the CPU run controller: controller states and the capture entry layout.
package cpu_run_pkg;

    localparam int CAP_DATA_W  = 16;
    localparam int CAP_STAMP_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RUN,
        DONE
    } run_state_t;

    typedef struct packed {
        logic [CAP_DATA_W-1:0]  data;
        logic [CAP_STAMP_W-1:0] stamp;
    } capture_entry_t;

endpackage

// File: rtl/cpu_run_controller_capture_fifo.sv
// Synchronous capture FIFO with a show-ahead head, occupancy count and simultaneous push/pop.
module capture_fifo
    import cpu_run_pkg::*;
#(
    parameter int DW    = 24,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [DW-1:0]              push_data_i,
    input  logic                       pop_i,
    output logic                       rd_valid_o,
    output logic [DW-1:0]              rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       drop_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty, full, pop_ok, push_ok;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        pop_ok   = pop_i && !empty;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok  = push_i && (!full || pop_ok);
        drop_o   = push_i && full && !pop_ok;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && push_ok && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign rd_valid_o = !empty;
    assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/cpu_run_controller.sv
// Run harness: holds the CPU in reset, runs it for a fixed budget and captures flagged outputs.
module cpu_run_controller
    import cpu_run_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 8,
    parameter int RESET_CYCLES = 2,
    parameter int RUN_CYCLES   = 16,
    parameter int CNTWIDTH     = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    output logic                       cpuReset,
    input  logic                       cpuOutFlag,
    input  logic [WIDTH-1:0]           cpuOut,
    output logic                       rdValid,
    input  logic                       rdReady,
    output logic [WIDTH-1:0]           rdData,
    output logic [CNTWIDTH-1:0]        rdStamp,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       done,
    output logic                       overflow
);

    localparam int HCW = $clog2(RESET_CYCLES+1);
    localparam int EW  = WIDTH + CNTWIDTH;

    run_state_t          state_q, state_d;
    logic [HCW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [CNTWIDTH-1:0] run_cnt_q, run_cnt_d;
    logic                overflow_q, overflow_d;
    logic                fifo_clear, fifo_push, fifo_drop;
    logic [EW-1:0]       head_entry;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        run_cnt_d  = run_cnt_q;
        fifo_clear = 1'b0;
        fifo_push  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                    fifo_clear = 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HCW'(RESET_CYCLES-1)) begin
                    state_d   = RUN;
                    run_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            RUN: begin
                // The last budgeted cycle is still sampled before leaving RUN.
                fifo_push = cpuOutFlag;
                run_cnt_d = run_cnt_q + CNTWIDTH'(1);
                if (run_cnt_q == CNTWIDTH'(RUN_CYCLES-1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (fifo_clear)     overflow_d = 1'b0;
        else if (fifo_drop) overflow_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            run_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            run_cnt_q  <= run_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    capture_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (fifo_clear),
        .push_i      (fifo_push),
        .push_data_i ({cpuOut, run_cnt_q}),
        .pop_i       (rdReady),
        .rd_valid_o  (rdValid),
        .rd_data_o   (head_entry),
        .count_o     (count),
        .drop_o      (fifo_drop)
    );

    assign rdData   = head_entry[EW-1:CNTWIDTH];
    assign rdStamp  = head_entry[CNTWIDTH-1:0];
    assign cpuReset = (state_q != RUN);
    assign done     = (state_q == DONE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: directed scenarios plus random traffic against a behavioural model.
module tb_cpu_run_controller;

    localparam int W   = 16;
    localparam int D   = 8;
    localparam int RC  = 2;
    localparam int NC  = 16;
    localparam int CNT = 8;
    localparam int CW  = $clog2(D+1);

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           cpuOutFlag = 1'b0;
    logic [W-1:0]   cpuOut = '0;
    logic           rdReady = 1'b0;
    logic           cpuReset, rdValid, done, overflow;
    logic [W-1:0]   rdData;
    logic [CNT-1:0] rdStamp;
    logic [CW-1:0]  count;

    cpu_run_controller #(
        .WIDTH(W), .DEPTH(D), .RESET_CYCLES(RC), .RUN_CYCLES(NC), .CNTWIDTH(CNT)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .cpuReset(cpuReset),
        .cpuOutFlag(cpuOutFlag), .cpuOut(cpuOut), .rdValid(rdValid), .rdReady(rdReady),
        .rdData(rdData), .rdStamp(rdStamp), .count(count), .done(done), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: m_since = cycles elapsed since start (-1 when idle); queue mirrors FIFO contents.
    typedef struct {
        logic [W-1:0]   d;
        logic [CNT-1:0] s;
    } ent_t;
    ent_t mq[$];
    int   m_since = -1;
    bit   m_ovf = 1'b0;

    function automatic bit m_in_run();
        return (m_since >= RC) && (m_since < RC + NC);
    endfunction

    function automatic bit m_is_done();
        return m_since >= RC + NC;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit do_pop;
        ent_t e;
        do_pop = (mq.size() != 0) && rdReady;
        if (!reset) begin
            m_since = -1;
            mq.delete();
            m_ovf = 1'b0;
        end else if ((m_since < 0 || m_is_done()) && start) begin
            m_since = 0;
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (m_in_run()) begin
                if (cpuOutFlag) begin
                    if (mq.size() < D) begin
                        e.d = cpuOut;
                        e.s = CNT'(m_since - RC);
                        mq.push_back(e);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                m_since++;
            end else if (m_since >= 0 && !m_is_done()) begin
                m_since++;
            end
        end
    endtask

    task automatic compare_all();
        logic [W-1:0]   ed;
        logic [CNT-1:0] es;
        ed = (mq.size() != 0) ? mq[0].d : '0;
        es = (mq.size() != 0) ? mq[0].s : '0;
        check("cpuReset", 32'(cpuReset), 32'(!m_in_run()));
        check("done",     32'(done),     32'(m_is_done()));
        check("rdValid",  32'(rdValid),  32'(mq.size() != 0));
        check("count",    32'(count),    32'(mq.size()));
        check("rdData",   32'(rdData),   32'(ed));
        check("rdStamp",  32'(rdStamp),  32'(es));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step(input bit rst_n, input bit st, input bit fl,
                        input logic [W-1:0] dat, input bit rdy);
        @(negedge clock);
        reset      = rst_n;
        start      = st;
        cpuOutFlag = fl;
        cpuOut     = dat;
        rdReady    = rdy;
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        int bias;
        // Reset with start held high must not launch a run.
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        check("rst_cpuReset", 32'(cpuReset), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        repeat (3) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        check("idle_cpuReset", 32'(cpuReset), 32'd1);
        check("idle_done", 32'(done), 32'd0);

        // Basic run: single flagged word on RUN cycle 3.
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        repeat (RC + NC) begin
            if (m_in_run() && (m_since - RC) == 3) step(1'b1, 1'b0, 1'b1, 16'h00A5, 1'b0);
            else                                   step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        end
        check("basic_done", 32'(done), 32'd1);
        check("basic_cpuReset", 32'(cpuReset), 32'd1);
        check("basic_count", 32'(count), 32'd1);
        check("basic_rdData", 32'(rdData), 32'h00A5);
        check("basic_rdStamp", 32'(rdStamp), 32'd3);

        // Drain in DONE.
        repeat (3) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("drain_rdValid", 32'(rdValid), 32'd0);
        check("drain_count", 32'(count), 32'd0);
        check("drain_done", 32'(done), 32'd1);

        // Overflow: flag every RUN cycle, no reads.
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        repeat (RC + NC) step(1'b1, 1'b0, m_in_run(), W'(m_since - RC), 1'b0);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < D; i++) begin
            check("ovf_stamp", 32'(rdStamp), 32'(i));
            check("ovf_data", 32'(rdData), 32'(i));
            step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        end
        check("ovf_empty", 32'(count), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Full with simultaneous pop; flag also driven during HOLD, which must not capture.
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        check("restart_overflow", 32'(overflow), 32'd0);
        repeat (RC) step(1'b1, 1'b0, 1'b1, 16'hDEAD, 1'b0);
        check("hold_nocapture", 32'(count), 32'd0);
        for (int k = 0; k < NC; k++) step(1'b1, 1'b0, 1'b1, W'(16'h100 + k), k >= D);
        check("fullpop_count", 32'(count), 32'd8);
        check("fullpop_overflow", 32'(overflow), 32'd0);
        check("fullpop_head", 32'(rdStamp), 32'd8);

        // Restart from DONE clears the FIFO, then reset mid-run.
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        check("restart_count", 32'(count), 32'd0);
        check("restart_cpuReset", 32'(cpuReset), 32'd1);
        for (int g = 0; g < 40 && !(m_in_run() && (m_since - RC) == 5); g++)
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)), W'($urandom), 1'b0);
        check("midrun_reached", 32'(m_since - RC), 32'd5);
        step(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
        check("midrun_cpuReset", 32'(cpuReset), 32'd1);
        check("midrun_count", 32'(count), 32'd0);
        check("midrun_done", 32'(done), 32'd0);
        repeat (2) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        check("midrun_idle", 32'(cpuReset), 32'd1);

        // Random traffic with varying read pressure.
        bias = 1;
        for (int n = 0; n < 1600; n++) begin
            if (n % 200 == 0) bias = $urandom_range(0, 4);
            step($urandom_range(0, 79) != 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1) == 1, W'($urandom),
                 $urandom_range(0, 3) < bias);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Synthesizable run-control and output-capture block for the parametrised CPU.
- Drives the CPU reset for a programmable number of cycles, then lets the CPU run for a fixed cycle budget.
- During the run it captures every flagged CPU output word, with a cycle stamp, into an internal FIFO; a valid/ready port drains the FIFO.
- Replaces hand-sequenced reset/clock stimulus with a repeatable, self-contained run harness usable in simulation and on hardware.

Parameters:
WIDTH, 16, width of CPU output word (matches CPU WIDTH)
DEPTH, 8, capture FIFO entries (power of two, >=2)
RESET_CYCLES, 2, cycles cpuReset is held high in HOLD (>=1)
RUN_CYCLES, 16, cycles the CPU runs before DONE (>=1, < 2**CNTWIDTH)
CNTWIDTH, 8, width of run cycle counter and stamp

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  begin a run; sampled only in IDLE or DONE
cpuReset  out  1  active-high reset to CPU
cpuOutFlag  in  1  CPU output-valid flag
cpuOut  in  WIDTH  CPU output word
rdValid  out  1  FIFO head valid
rdReady  in  1  consumer accepts head
rdData  out  WIDTH  captured word at FIFO head
rdStamp  out  CNTWIDTH  run cycle index of head word
count  out  $clog2(DEPTH+1)  FIFO occupancy
done  out  1  run budget exhausted
overflow  out  1  sticky: a flagged word was dropped while FIFO full

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE; cpuReset=1; FIFO empty (count=0, rdValid=0); rdData=0; rdStamp=0; done=0; overflow=0; run counter=0.
- States: IDLE, HOLD, RUN, DONE (shared enum).
- IDLE: cpuReset=1. start=1 -> HOLD; same edge clears FIFO pointers, overflow, and the hold counter.
- HOLD: cpuReset=1 for exactly RESET_CYCLES cycles, then -> RUN with run counter=0. start is ignored.
- RUN: cpuReset=0.
  - Each cycle the run counter increments.
  - In the cycle where the counter == RUN_CYCLES-1, transition to DONE; that cycle is still sampled.
  - start is ignored.
- Capture: in any RUN cycle with cpuOutFlag=1, push {cpuOut, counter}. The first RUN cycle has stamp 0. Samples outside RUN are never captured.
- Capture latency: a word sampled at edge k is visible on rdData/rdStamp with rdValid=1 after edge k (next cycle) if the FIFO was empty.
- FIFO: show-ahead head. rdValid = (count!=0) in every state.
  - Pop on rdValid && rdReady.
  - count updates the cycle after push/pop.
- Full boundary:
  - Push while full and no pop: word dropped, overflow<=1 (sticky until next start or reset).
  - Push while full with a simultaneous pop: push accepted, count unchanged, no overflow.
- Empty boundary: rdReady with rdValid=0 has no effect. Push and pop on an empty FIFO leaves count=1 after the cycle.
- Pointer wrap: modulo DEPTH; count distinguishes full from empty.
- DONE: done=1, cpuReset=1, FIFO still drainable. start=1 -> HOLD; clears FIFO, overflow, done.
- reset low during HOLD/RUN/DONE: immediate return to reset values at that edge; the in-progress run is abandoned.
- Widths: counter wraps are impossible by parameter constraint; rdStamp is zero-extended if fewer bits are used.

Decomposition:
- Package cpu_run_pkg: state enum (IDLE, HOLD, RUN, DONE); capture entry struct {data[WIDTH], stamp[CNTWIDTH]} parametrised via localparam widths.
- One sub-module: capture_fifo (synchronous FIFO with show-ahead head, count, full/empty, simultaneous push/pop). The controller FSM, hold counter and run counter stay in cpu_run_controller.

Test Plan:
- Reset: hold reset=0 two cycles with start=1 -> cpuReset=1, done=0, count=0, rdValid=0, overflow=0; state stays IDLE after reset releases until start.
- Basic run (defaults): pulse start; cpuOutFlag=1 with cpuOut=16'h00A5 on RUN cycle 3 only -> cpuReset high for 2 cycles then low for 16; done=1 after 16 RUN cycles; rdData=16'h00A5, rdStamp=3, count=1.
- Drain: after the basic run, hold rdReady=1 -> one handshake, then rdValid=0, count=0; done stays 1.
- Overflow: DEPTH=8, cpuOutFlag=1 all 16 RUN cycles, cpuOut=cycle index, rdReady=0 -> count=8, overflow=1, stamps 0..7 read in order.
- Full with simultaneous pop: fill to 8, then hold rdReady=1 with cpuOutFlag=1 -> count stays 8, overflow stays 0, words emerge in order.
- Restart and mid-run reset: start in DONE -> FIFO cleared, overflow=0, new HOLD. Assert reset=0 at RUN cycle 5 -> next cycle IDLE, cpuReset=1, count=0.
